// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between a core (m0)
// and a debug/loader port (m1); read data returns one cycle after the grant.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);
  logic lsp, pend, owner;
  // On a tie the requester that was not served last wins
  always_comb begin
    m0_gnt    = ~rst & m0_req & (~m1_req | lsp);
    m1_gnt    = ~rst & m1_req & (~m0_req | ~lsp);
    mem_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
    mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
    mem_we    = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 1'b0;
    mem_be    = m0_gnt ? m0_be    : m1_gnt ? m1_be    : 4'b0000;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lsp   <= 1'b1;
      pend  <= 1'b0;
      owner <= 1'b0;
    end else begin
      if (m0_gnt | m1_gnt) lsp <= m1_gnt;
      pend  <= (m0_gnt | m1_gnt) & ~mem_we;
      owner <= m1_gnt;
    end
  assign m0_rvalid = pend & ~owner;
  assign m1_rvalid = pend & owner;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized two-master stream checked
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_rdata = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int tests = 0, failed = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h44; m0_be = 4'hf; m0_wdata = 32'h1234; m0_we = 1;
    m1_req = 1; m1_addr = 32'h88; m1_be = 4'hf;
    #1;
    tests++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0 || mem_be !== 4'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failed++;
      $display("FAIL reset_outputs: gnt=%b%b rv=%b%b we=%b be=%h addr=%h wdata=%h, required all 0",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_be, mem_addr, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h4; m0_be = 4'hf;
    #1;
    tests++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || mem_addr !== 32'h4 || mem_we !== 0) begin
      failed++;
      $display("FAIL single_read_gnt: gnt=%b%b addr=%h we=%b, required gnt=10 addr=4 we=0",
               m0_gnt, m1_gnt, mem_addr, mem_we);
    end
    @(negedge clk);
    clear_inputs();
    mem_rdata = 32'h00500113;
    #1;
    tests++;
    if (m0_rvalid !== 1 || m1_rvalid !== 0 || m0_rdata !== 32'h00500113 || m0_gnt !== 0) begin
      failed++;
      $display("FAIL single_read_rvalid: rv=%b%b rdata=%h gnt0=%b, required rv=10 rdata=00500113 gnt0=0",
               m0_rvalid, m1_rvalid, m0_rdata, m0_gnt);
    end
    @(negedge clk);
    #1;
    tests++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
      failed++;
      $display("FAIL single_read_one_shot: rv=%b%b, required 00", m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    logic [31:0] exp_a [4];
    logic [1:0] prev;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{32'h10, 32'h20, 32'h10, 32'h20};
    prev = 2'b00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_be = 4'hf;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_be = 4'hf;
      end else clear_inputs();
      mem_rdata = 32'hA000_0000 + i;
      #1;
      tests++;
      if (i < 4 && ({m1_gnt, m0_gnt} !== exp_g[i] || mem_addr !== exp_a[i])) begin
        failed++;
        $display("FAIL tie_grant[%0d]: gnt(m1m0)=%b addr=%h, required %b addr=%h",
                 i, {m1_gnt, m0_gnt}, mem_addr, exp_g[i], exp_a[i]);
      end
      tests++;
      if ({m1_rvalid, m0_rvalid} !== prev || m0_rdata !== mem_rdata) begin
        failed++;
        $display("FAIL tie_rvalid[%0d]: rv(m1m0)=%b rdata=%h, required %b rdata=%h",
                 i, {m1_rvalid, m0_rvalid}, m0_rdata, prev, mem_rdata);
      end
      prev = (i < 4) ? exp_g[i] : 2'b00;
    end
  endtask

  task automatic test_write();
    do_reset();
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'hDEADBEEF; m1_be = 4'b0011;
    #1;
    tests++;
    if (m1_gnt !== 1 || m0_gnt !== 0 || mem_we !== 1 || mem_be !== 4'b0011 ||
        mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h8) begin
      failed++;
      $display("FAIL write_cycle: gnt=%b%b we=%b be=%b wdata=%h addr=%h, required gnt1 we=1 be=0011 wdata=deadbeef addr=8",
               m0_gnt, m1_gnt, mem_we, mem_be, mem_wdata, mem_addr);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    tests++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0 || mem_we !== 0 || mem_be !== 0) begin
      failed++;
      $display("FAIL write_no_rvalid: rv=%b%b we=%b be=%b, required all 0",
               m0_rvalid, m1_rvalid, mem_we, mem_be);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h4; m0_be = 4'hf;
    #1;
    tests++;
    if (m0_gnt !== 1) begin
      failed++;
      $display("FAIL midrst_gnt: m0_gnt=%b, required 1", m0_gnt);
    end
    @(negedge clk);
    rst = 1;
    m1_req = 1; m1_addr = 32'h20; m1_be = 4'hf;
    #1;
    tests++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0 || mem_be !== 0 ||
        mem_addr !== 0 || mem_wdata !== 0) begin
      failed++;
      $display("FAIL midrst_outputs: gnt=%b%b rv=%b%b we=%b be=%h addr=%h, required all 0",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_be, mem_addr);
    end
    @(negedge clk);
    rst = 0;
    m0_req = 0;
    #1;
    tests++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0 || m1_gnt !== 1 || mem_addr !== 32'h20) begin
      failed++;
      $display("FAIL midrst_release: rv=%b%b gnt1=%b addr=%h, required rv=00 gnt1=1 addr=20",
               m0_rvalid, m1_rvalid, m1_gnt, mem_addr);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    tests++;
    if (m0_rvalid !== 0 || m1_rvalid !== 1) begin
      failed++;
      $display("FAIL midrst_first_read: rv=%b%b, required 01", m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_idle_lsp();
    do_reset();
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h10; m0_be = 4'hf;
    m1_req = 1; m1_addr = 32'h20; m1_be = 4'hf;
    #1;
    tests++;
    if (m0_gnt !== 1 || m1_gnt !== 0) begin
      failed++;
      $display("FAIL idle_first_tie: gnt=%b%b, required 10", m0_gnt, m1_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      m0_addr = 32'h55; m0_wdata = 32'h66; m0_be = 4'hf; m0_we = 1;
      #1;
      tests++;
      if (m0_gnt !== 0 || m1_gnt !== 0 || mem_we !== 0 || mem_be !== 0 ||
          mem_addr !== 0 || mem_wdata !== 0) begin
        failed++;
        $display("FAIL idle[%0d]: gnt=%b%b we=%b be=%h addr=%h wdata=%h, required all 0",
                 i, m0_gnt, m1_gnt, mem_we, mem_be, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_be = 4'hf;
    #1;
    tests++;
    if (m0_gnt !== 0 || m1_gnt !== 1) begin
      failed++;
      $display("FAIL idle_lsp_kept: gnt=%b%b, required 01", m0_gnt, m1_gnt);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Transaction-level reference: each master holds a request until granted,
  // ties go to whoever was not served last, each read expects one return next cycle.
  task automatic test_random();
    bit r [2];
    logic w [2];
    logic [31:0] a [2], d [2];
    logic [3:0] b [2];
    int wait_c [2];
    int last, g, eo;
    int rv_q [$];
    do_reset();
    last = 1;
    for (int n = 0; n < 2; n++) begin r[n] = 0; wait_c[n] = 0; end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++)
        if (!r[n] && $urandom_range(0, 9) < 6) begin
          r[n] = 1; w[n] = 1'($urandom_range(0, 1));
          a[n] = $urandom; d[n] = $urandom; b[n] = 4'($urandom);
        end
      m0_req = r[0]; m0_we = w[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_be = b[0];
      m1_req = r[1]; m1_we = w[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_be = b[1];
      mem_rdata = $urandom;
      #1;
      g = (r[0] && r[1]) ? 1 - last : r[0] ? 0 : r[1] ? 1 : -1;
      eo = (rv_q.size() > 0) ? rv_q.pop_front() : -1;
      tests++;
      if (m0_gnt & m1_gnt) begin
        failed++;
        $display("FAIL rand_mutex[%0d]: both grants high", c);
      end
      tests++;
      if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin
        failed++;
        $display("FAIL rand_gnt[%0d]: gnt(m1m0)=%b%b, required winner %0d", c, m1_gnt, m0_gnt, g);
      end
      tests++;
      if (g >= 0 ? (mem_addr !== a[g] || mem_wdata !== d[g] || mem_we !== w[g] || mem_be !== b[g])
                 : (mem_addr !== 0 || mem_wdata !== 0 || mem_we !== 0 || mem_be !== 0)) begin
        failed++;
        $display("FAIL rand_mux[%0d]: addr=%h wdata=%h we=%b be=%h for winner %0d",
                 c, mem_addr, mem_wdata, mem_we, mem_be, g);
      end
      tests++;
      if (m0_rvalid !== (eo == 0) || m1_rvalid !== (eo == 1) ||
          (eo >= 0 && (m0_rdata !== mem_rdata || m1_rdata !== mem_rdata))) begin
        failed++;
        $display("FAIL rand_rvalid[%0d]: rv(m1m0)=%b%b rdata=%h/%h, required owner %0d rdata=%h",
                 c, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata, eo, mem_rdata);
      end
      for (int n = 0; n < 2; n++)
        if (r[n] && g != n) wait_c[n]++;
      tests++;
      if (wait_c[0] > 1 || wait_c[1] > 1) begin
        failed++;
        $display("FAIL rand_starve[%0d]: waits=%0d/%0d, required <=1", c, wait_c[0], wait_c[1]);
      end
      if (g >= 0) begin
        last = g;
        if (!w[g]) rv_q.push_back(g);
        r[g] = 0;
        wait_c[g] = 0;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_idle_lsp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
